// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, reset/NOP constants and the fetch-state encoding.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC  = 32'h0001_0000;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StHold
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding register used while decode is stalled.
module if_skid_buf
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] wr_pc,
   input  logic [XLEN-1:0] wr_instr,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= wr_pc;
         instr <= wr_instr;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem reads, IF/ID register, skid buffer
// for decode stalls and squashing of in-flight/queued fetches on redirect.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_i,
   input  logic            flush_i,
   input  logic            stall_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            pc_adv_o,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_instr_o
);

   fetch_state_e    state, state_next;
   logic [XLEN-1:0] req_pc, req_pc_next;
   logic            fresh, fresh_next;
   logic            drop, drop_next;
   logic            resp_ok, can_load;
   logic            if_load;
   logic [XLEN-1:0] if_load_pc, if_load_instr;
   logic            skid_load, skid_clear, skid_valid;
   logic [XLEN-1:0] skid_pc, skid_instr;

   // fresh marks the first REQ cycle: the PC unit has only just advanced, so the
   // address comes straight from pc_i and is captured into req_pc for later cycles.
   assign resp_ok  = (state == StWait) && imem_rvalid_i && !drop && !flush_i;
   assign can_load = !stall_i || !if_valid_o;

   always_comb begin
      state_next    = state;
      req_pc_next   = req_pc;
      fresh_next    = 1'b0;
      drop_next     = drop;
      imem_req_o    = 1'b0;
      imem_addr_o   = word_align(fresh ? pc_i : req_pc);
      pc_adv_o      = 1'b0;
      if_load       = 1'b0;
      if_load_pc    = req_pc;
      if_load_instr = imem_rdata_i;
      skid_load     = 1'b0;
      skid_clear    = 1'b0;
      unique case (state)
         StIdle: begin
            state_next = StReq;
            fresh_next = 1'b1;
         end
         StReq: begin
            imem_req_o = 1'b1;
            if (fresh) req_pc_next = pc_i;
            if (imem_ready_i) begin
               state_next = StWait;
               drop_next  = flush_i;
            end else if (flush_i) begin
               fresh_next = 1'b1;
            end
         end
         StWait: begin
            if (imem_rvalid_i) begin
               drop_next  = 1'b0;
               state_next = StReq;
               fresh_next = 1'b1;
               if (resp_ok) begin
                  pc_adv_o = 1'b1;
                  if (can_load) begin
                     if_load = 1'b1;
                  end else begin
                     skid_load  = 1'b1;
                     state_next = StHold;
                     fresh_next = 1'b0;
                  end
               end
            end else if (flush_i) begin
               drop_next = 1'b1;
            end
         end
         StHold: begin
            if (flush_i) begin
               skid_clear = 1'b1;
               state_next = StReq;
               fresh_next = 1'b1;
            end else if (!stall_i) begin
               if_load       = skid_valid;
               if_load_pc    = skid_pc;
               if_load_instr = skid_instr;
               skid_clear    = 1'b1;
               state_next    = StReq;
               fresh_next    = 1'b1;
            end
         end
         default: state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= StIdle;
         req_pc <= RESET_PC;
         fresh  <= 1'b0;
         drop   <= 1'b0;
      end else begin
         state  <= state_next;
         req_pc <= req_pc_next;
         fresh  <= fresh_next;
         drop   <= drop_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid_o <= 1'b0;
         if_pc_o    <= '0;
         if_instr_o <= NOP_INSTR;
      end else if (flush_i) begin
         if_valid_o <= 1'b0;
         if_instr_o <= NOP_INSTR;
      end else if (!(stall_i && if_valid_o)) begin
         if (if_load) begin
            if_valid_o <= 1'b1;
            if_pc_o    <= if_load_pc;
            if_instr_o <= if_load_instr;
         end else begin
            if_valid_o <= 1'b0;
            if_instr_o <= NOP_INSTR;
         end
      end
   end

   if_skid_buf u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (skid_load),
      .clear    (skid_clear),
      .wr_pc    (req_pc),
      .wr_instr (imem_rdata_i),
      .valid    (skid_valid),
      .pc       (skid_pc),
      .instr    (skid_instr)
   );

endmodule
